// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I sequencer: FETCH -> DECODE -> EXEC -> MEM -> WB with memory
// timeout, sticky trap and a retired-instruction counter.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_FETCH  | read instruction at PC, load IR on mem_ready
// S_DECODE | classify instr[6:0] into the latched class
// S_EXEC   | ALU operation; branches resolve and retire here
// S_MEM    | load/store access at the ALU address; stores retire here
// S_WB     | register write-back, PC+4, retire
// S_TRAP   | halted until reset, trap_cause held
module multicycle_ctrl #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      instr,
    input  logic             mem_ready,
    input  logic             branch_taken,
    output logic             mem_req,
    output logic             mem_we,
    output logic             addr_sel,
    output logic             ir_we,
    output logic             pc_we,
    output logic             pc_sel,
    output logic             alu_src,
    output logic [1:0]       alu_op,
    output logic             reg_we,
    output logic             wb_sel,
    output logic             trap,
    output logic [1:0]       trap_cause,
    output logic [CNT_W-1:0] retired
);

    localparam int TW = $clog2(MEM_TIMEOUT + 1);

    typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP} state_t;
    typedef enum logic [2:0] {C_NONE, C_R, C_I, C_LOAD, C_STORE, C_BRANCH} cls_t;

    state_t state, state_nxt;
    cls_t   cls, cls_nxt;
    logic [1:0]    cause, cause_nxt;
    logic [TW-1:0] tmo_cnt;
    logic          retire, tmo_hit;

    logic mem_req_d, mem_we_d, addr_sel_d, ir_we_d, pc_we_d, pc_sel_d;
    logic alu_src_d, reg_we_d, wb_sel_d, trap_d;
    logic [1:0] alu_op_d;
    logic alu_src_c;
    logic [1:0] alu_op_c;

    logic unused_instr_bits;
    assign unused_instr_bits = ^instr[31:7];

    function automatic cls_t decode_cls(input logic [6:0] opc);
        case (opc)
            7'b0110011: decode_cls = C_R;
            7'b0010011: decode_cls = C_I;
            7'b0000011: decode_cls = C_LOAD;
            7'b0100011: decode_cls = C_STORE;
            7'b1100011: decode_cls = C_BRANCH;
            default:    decode_cls = C_NONE;
        endcase
    endfunction

    assign tmo_hit = (tmo_cnt == TW'(MEM_TIMEOUT - 1));

    always_comb begin
        alu_src_c = 1'b0;
        alu_op_c  = 2'b00;
        case (cls)
            C_R:      begin alu_src_c = 1'b0; alu_op_c = 2'b10; end
            C_I:      begin alu_src_c = 1'b1; alu_op_c = 2'b10; end
            C_LOAD,
            C_STORE:  begin alu_src_c = 1'b1; alu_op_c = 2'b00; end
            C_BRANCH: begin alu_src_c = 1'b0; alu_op_c = 2'b01; end
            default:  begin alu_src_c = 1'b0; alu_op_c = 2'b00; end
        endcase
    end

    always_comb begin
        state_nxt  = state;
        cls_nxt    = cls;
        cause_nxt  = cause;
        retire     = 1'b0;
        mem_req_d  = 1'b0;
        mem_we_d   = 1'b0;
        addr_sel_d = 1'b0;
        ir_we_d    = 1'b0;
        pc_we_d    = 1'b0;
        pc_sel_d   = 1'b0;
        alu_src_d  = 1'b0;
        alu_op_d   = 2'b00;
        reg_we_d   = 1'b0;
        wb_sel_d   = 1'b0;
        trap_d     = 1'b0;
        case (state)
            S_FETCH: begin
                mem_req_d = 1'b1;
                if (mem_ready) begin
                    ir_we_d   = 1'b1;
                    state_nxt = S_DECODE;
                end else if (tmo_hit) begin
                    state_nxt = S_TRAP;
                    cause_nxt = 2'b10;
                end
            end
            S_DECODE: begin
                cls_nxt = decode_cls(instr[6:0]);
                if (cls_nxt == C_NONE) begin
                    state_nxt = S_TRAP;
                    cause_nxt = 2'b01;
                end else begin
                    state_nxt = S_EXEC;
                end
            end
            S_EXEC: begin
                alu_src_d = alu_src_c;
                alu_op_d  = alu_op_c;
                case (cls)
                    C_R, C_I:         state_nxt = S_WB;
                    C_LOAD, C_STORE:  state_nxt = S_MEM;
                    C_BRANCH: begin
                        pc_we_d   = 1'b1;
                        pc_sel_d  = branch_taken;
                        retire    = 1'b1;
                        state_nxt = S_FETCH;
                    end
                    default: begin
                        state_nxt = S_TRAP;
                        cause_nxt = 2'b01;
                    end
                endcase
            end
            S_MEM: begin
                // ALU controls held so the access address stays stable across waits
                mem_req_d  = 1'b1;
                addr_sel_d = 1'b1;
                mem_we_d   = (cls == C_STORE);
                alu_src_d  = alu_src_c;
                alu_op_d   = alu_op_c;
                if (mem_ready) begin
                    if (cls == C_LOAD) begin
                        state_nxt = S_WB;
                    end else begin
                        pc_we_d   = 1'b1;
                        retire    = 1'b1;
                        state_nxt = S_FETCH;
                    end
                end else if (tmo_hit) begin
                    state_nxt = S_TRAP;
                    cause_nxt = 2'b10;
                end
            end
            S_WB: begin
                alu_src_d = alu_src_c;
                alu_op_d  = alu_op_c;
                reg_we_d  = 1'b1;
                wb_sel_d  = (cls == C_LOAD);
                pc_we_d   = 1'b1;
                retire    = 1'b1;
                state_nxt = S_FETCH;
            end
            S_TRAP: begin
                trap_d = 1'b1;
            end
            default: state_nxt = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_FETCH;
            cls     <= C_NONE;
            cause   <= 2'b00;
            retired <= '0;
            tmo_cnt <= '0;
        end else begin
            state <= state_nxt;
            cls   <= cls_nxt;
            cause <= cause_nxt;
            if (retire) retired <= retired + CNT_W'(1);
            // any state change clears the wait counter, covering entry to FETCH and MEM
            if (state_nxt != state) tmo_cnt <= '0;
            else if (mem_req_d && !mem_ready) tmo_cnt <= tmo_cnt + TW'(1);
        end
    end

    // reset forces every strobe and select low even though the state reads FETCH
    assign mem_req    = rst_n & mem_req_d;
    assign mem_we     = rst_n & mem_we_d;
    assign addr_sel   = rst_n & addr_sel_d;
    assign ir_we      = rst_n & ir_we_d;
    assign pc_we      = rst_n & pc_we_d;
    assign pc_sel     = rst_n & pc_sel_d;
    assign alu_src    = rst_n & alu_src_d;
    assign alu_op     = {2{rst_n}} & alu_op_d;
    assign reg_we     = rst_n & reg_we_d;
    assign wb_sel     = rst_n & wb_sel_d;
    assign trap       = rst_n & trap_d;
    assign trap_cause = cause;

endmodule
